// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the unified memory port: round-robin on ties,
// bounded locked bursts, and a one-cycle registered read return.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 8
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    input  logic [1:0]              m_req,
    input  logic [1:0]              m_we,
    input  logic [1:0]              m_lock,
    input  logic [2*ADDR_WIDTH-1:0] m_addr,
    input  logic [2*DATA_WIDTH-1:0] m_wdata,
    output logic [1:0]              m_gnt,
    output logic [1:0]              m_rvalid,
    output logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data_in,
    input  logic [DATA_WIDTH-1:0]   mem_data_out
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    state_t                state_q, state_d;
    logic                  rr_last_q, rr_last_d;
    logic [7:0]            burst_q, burst_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            gnt;
    logic [7:0]            burst_inc;

    assign burst_inc = (burst_q >= BURST_MAX) ? BURST_MAX : burst_q + 8'd1;

    // An owner keeps the port unless its cap is reached and the other master waits.
    always_comb begin
        gnt = 2'b00;
        if (!sys_rst) begin
            if (state_q == OWN0 && m_req[0]) begin
                gnt = (burst_q == BURST_MAX && m_req[1]) ? 2'b10 : 2'b01;
            end else if (state_q == OWN1 && m_req[1]) begin
                gnt = (burst_q == BURST_MAX && m_req[0]) ? 2'b01 : 2'b10;
            end else begin
                case (m_req)
                    2'b01:   gnt = 2'b01;
                    2'b10:   gnt = 2'b10;
                    2'b11:   gnt = rr_last_q ? 2'b01 : 2'b10;
                    default: gnt = 2'b00;
                endcase
            end
        end
    end

    always_comb begin
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        if (gnt[0]) begin
            mem_wr_en   = m_we[0];
            mem_addr    = m_addr[0 +: ADDR_WIDTH];
            mem_data_in = m_wdata[0 +: DATA_WIDTH];
        end else if (gnt[1]) begin
            mem_wr_en   = m_we[1];
            mem_addr    = m_addr[ADDR_WIDTH +: ADDR_WIDTH];
            mem_data_in = m_wdata[DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d   = IDLE;
        burst_d   = 8'd0;
        rr_last_d = rr_last_q;
        if (gnt[0]) begin
            rr_last_d = 1'b0;
            if (m_lock[0]) begin
                state_d = OWN0;
                burst_d = (state_q == OWN0) ? burst_inc : 8'd1;
            end
        end else if (gnt[1]) begin
            rr_last_d = 1'b1;
            if (m_lock[1]) begin
                state_d = OWN1;
                burst_d = (state_q == OWN1) ? burst_inc : 8'd1;
            end
        end
        rvalid_d = gnt & ~m_we;
        rdata_d  = (|rvalid_d) ? mem_data_out : rdata_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            burst_q   <= 8'd0;
            rvalid_q  <= 2'b00;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            burst_q   <= burst_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    assign m_gnt    = gnt;
    assign m_rvalid = rvalid_q;
    assign m_rdata  = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset gating, round-robin, read
// latency, write pass-through, burst cap and reset in the middle of a burst.
module tb_mem_port_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  m_req, m_we, m_lock;
    logic [63:0] m_addr, m_wdata;
    logic [1:0]  m_gnt, m_rvalid;
    logic [31:0] m_rdata;
    logic        mem_wr_en;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] A0 = 32'h0000_0010;
    localparam logic [31:0] A1 = 32'h0000_0040;

    mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(8)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_req(m_req), .m_we(m_we), .m_lock(m_lock),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        sys_rst      = 1'b1;
        m_req        = 2'b11;
        m_we         = 2'b11;
        m_lock       = 2'b00;
        m_addr       = {A1, A0};
        m_wdata      = {32'h2222_2222, 32'h1111_1111};
        mem_data_out = 32'h0;

        // Reset with both masters requesting writes
        cyc(); cyc();
        #1;
        chk("rst_gnt", 32'(m_gnt), 32'h0);
        chk("rst_wr_en", 32'(mem_wr_en), 32'h0);
        chk("rst_rvalid", 32'(m_rvalid), 32'h0);
        chk("rst_rdata", m_rdata, 32'h0);

        // Round-robin: 01, 10, 01, 10 with read data tracking each grant
        cyc();
        sys_rst = 1'b0;
        m_we    = 2'b00;
        for (int i = 0; i < 4; i++) begin
            mem_data_out = 32'hC0DE_0000 + 32'(i);
            #1;
            chk("rr_gnt", 32'(m_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_addr", mem_addr, (i % 2 == 0) ? A0 : A1);
            cyc();
            chk("rr_rvalid", 32'(m_rvalid), (i % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_rdata", m_rdata, 32'hC0DE_0000 + 32'(i));
        end

        // Read latency: master 0 reads A0
        m_req        = 2'b01;
        mem_data_out = 32'hDEAD_BEEF;
        #1;
        chk("rd_gnt", 32'(m_gnt), 32'h1);
        chk("rd_addr", mem_addr, A0);
        cyc();
        m_req        = 2'b00;
        mem_data_out = 32'h0;
        #1;
        chk("rd_rvalid", 32'(m_rvalid), 32'h1);
        chk("rd_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("idle_gnt", 32'(m_gnt), 32'h0);
        chk("idle_addr", mem_addr, 32'h0);
        cyc();
        chk("rd_rvalid_clr", 32'(m_rvalid), 32'h0);
        chk("rd_rdata_hold", m_rdata, 32'hDEAD_BEEF);

        // Write pass-through from master 1
        m_req   = 2'b10;
        m_we    = 2'b10;
        m_wdata = {32'hA5A5_0000, 32'h1111_1111};
        #1;
        chk("wr_gnt", 32'(m_gnt), 32'h2);
        chk("wr_en", 32'(mem_wr_en), 32'h1);
        chk("wr_addr", mem_addr, A1);
        chk("wr_data", mem_data_in, 32'hA5A5_0000);
        cyc();
        m_req = 2'b00;
        m_we  = 2'b00;
        chk("wr_rvalid", 32'(m_rvalid), 32'h0);
        chk("wr_rdata_hold", m_rdata, 32'hDEAD_BEEF);

        // Burst cap: master 1 locked, master 0 joins on the 3rd grant
        m_req  = 2'b10;
        m_lock = 2'b10;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) m_req = 2'b11;
            #1;
            chk("burst_m1", 32'(m_gnt), 32'h2);
            cyc();
        end
        #1;
        chk("burst_release", 32'(m_gnt), 32'h1);
        cyc();
        m_req = 2'b10;
        #1;
        chk("burst_resume", 32'(m_gnt), 32'h2);
        cyc();
        m_req  = 2'b00;
        m_lock = 2'b00;
        cyc();

        // Reset mid-burst: master 0 locked reads, reset after 5 grants
        m_req  = 2'b01;
        m_lock = 2'b01;
        for (int k = 1; k <= 5; k++) begin
            mem_data_out = 32'h5500_0000 + 32'(k);
            #1;
            chk("lock0_gnt", 32'(m_gnt), 32'h1);
            cyc();
        end
        sys_rst = 1'b1;
        #1;
        chk("midrst_gnt", 32'(m_gnt), 32'h0);
        cyc();
        sys_rst = 1'b0;
        chk("midrst_rvalid", 32'(m_rvalid), 32'h0);
        chk("midrst_rdata", m_rdata, 32'h0);
        // Fresh burst: 8 grants to master 0 while master 1 waits, then release
        m_req = 2'b11;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk("post_rst_m0", 32'(m_gnt), 32'h1);
            cyc();
        end
        #1;
        chk("post_rst_release", 32'(m_gnt), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
